// File: rtl/pc_unit.sv
// Program counter with sequential/jump/branch/call/return successor logic and a return-address stack.
// Latency: one cycle from op to current_address; next_address is combinational.
// Backpressure: stall=1 freezes the PC, the stack and both flags; next_address then echoes current_address.
//
// Ports:
//   clock, reset      single clock; synchronous active-high reset (overrides stall and op)
//   stall             hold all state this cycle
//   op                000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101-111 act as INC
//   cond              branch condition (BRANCH only)
//   target            absolute destination for JUMP/CALL
//   offset            signed displacement for BRANCH, relative to current_address
//   current_address   registered fetch address
//   next_address      value loaded at the next edge
//   stack_depth       valid return-stack entries (0..STACK_DEPTH)
//   stack_overflow    sticky: CALL while stack full
//   stack_underflow   sticky: RET while stack empty
module pc_unit #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    STACK_DEPTH  = 4,
  localparam int                   DW           = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [2:0]            op,
  input  logic                  cond,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic [ADDR_WIDTH-1:0] offset,
  output logic [ADDR_WIDTH-1:0] current_address,
  output logic [ADDR_WIDTH-1:0] next_address,
  output logic [DW-1:0]         stack_depth,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);

  typedef enum logic [2:0] {
    OP_INC    = 3'b000,
    OP_JUMP   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100
  } op_e;

  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [DW-1:0]         ONE_D     = DW'(1);
  localparam logic [DW-1:0]         DEPTH_MAX = DW'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] stack_d [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic [ADDR_WIDTH-1:0] tos;
  logic                  stack_full;
  logic                  stack_empty;

  always_comb begin
    pc_plus1    = pc_q + ONE_A;
    stack_full  = (depth_q == DEPTH_MAX);
    stack_empty = (depth_q == '0);

    // Top-of-stack selected by comparison rather than indexing, so the
    // depth counter (which must reach STACK_DEPTH) never needs narrowing.
    tos = pc_plus1;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (DW'(i) == depth_q - ONE_D) tos = stack_q[i];
    end

    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;

    if (!stall) begin
      case (op_e'(op))
        OP_JUMP:   pc_d = target;
        OP_BRANCH: pc_d = cond ? (pc_q + offset) : pc_plus1;
        OP_CALL: begin
          pc_d = target;
          if (stack_full) begin
            // Push is dropped; the jump still happens.
            ovf_d = 1'b1;
          end else begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
              if (DW'(i) == depth_q) stack_d[i] = pc_plus1;
            end
            depth_d = depth_q + ONE_D;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            pc_d  = pc_plus1;
            unf_d = 1'b1;
          end else begin
            pc_d    = tos;
            depth_d = depth_q - ONE_D;
          end
        end
        default:   pc_d = pc_plus1;  // INC and reserved encodings
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry contents carry no reset: they are only read below depth_q,
  // and depth_q is cleared on reset.
  always_ff @(posedge clock) begin
    stack_q <= stack_d;
  end

  assign current_address = pc_q;
  assign next_address    = pc_d;
  assign stack_depth     = depth_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  localparam int AW  = 8;
  localparam int SD  = 4;
  localparam int DW  = $clog2(SD + 1);
  localparam int MOD = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic [2:0]    op    = 3'b000;
  logic          cond  = 1'b0;
  logic [AW-1:0] target = '0;
  logic [AW-1:0] offset = '0;
  logic [AW-1:0] current_address;
  logic [AW-1:0] next_address;
  logic [DW-1:0] stack_depth;
  logic          stack_overflow;
  logic          stack_underflow;

  pc_unit #(.ADDR_WIDTH(AW), .RESET_VECTOR(8'h00), .STACK_DEPTH(SD)) dut (
    .clock(clock), .reset(reset), .stall(stall), .op(op), .cond(cond),
    .target(target), .offset(offset), .current_address(current_address),
    .next_address(next_address), .stack_depth(stack_depth),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: PC as an integer, return stack as a queue.
  int unsigned m_pc;
  int unsigned m_stk[$];
  bit          m_ovf;
  bit          m_unf;
  int unsigned exp_nxt;
  logic [AW-1:0] obs_nxt;

  function automatic int unsigned model_next(input logic [2:0] o, input logic c,
                                             input logic [AW-1:0] t, input logic [AW-1:0] off);
    case (o)
      3'd1:    return int'(t);
      3'd2:    return c ? (m_pc + int'(off)) % MOD : (m_pc + 1) % MOD;
      3'd3:    return int'(t);
      3'd4:    return (m_stk.size() > 0) ? m_stk[$] : (m_pc + 1) % MOD;
      default: return (m_pc + 1) % MOD;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit s, input logic [2:0] o, input logic c,
                            input logic [AW-1:0] t, input logic [AW-1:0] off);
    int unsigned nxt;
    if (r) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (!s) begin
      nxt = model_next(o, c, t, off);
      if (o == 3'd3) begin
        if (m_stk.size() < SD) m_stk.push_back((m_pc + 1) % MOD);
        else m_ovf = 1;
      end
      if (o == 3'd4) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_unf = 1;
      end
      m_pc = nxt;
    end
  endtask

  // Drive one cycle: set inputs, sample next_address mid-cycle, advance the
  // model, then return 1 time unit after the active edge.
  task automatic cycle(input bit r, input bit s, input logic [2:0] o, input logic c,
                       input logic [AW-1:0] t, input logic [AW-1:0] off);
    reset = r; stall = s; op = o; cond = c; target = t; offset = off;
    #2;
    obs_nxt = next_address;
    exp_nxt = s ? m_pc : model_next(o, c, t, off);
    model_step(r, s, o, c, t, off);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic [AW-1:0] exp_pc [3] = '{8'h01, 8'h02, 8'h03};
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0, 3'd1, 0, 8'hAA, 0);
      n_tests++;
      if (current_address !== 8'h00 || stack_depth !== '0 || stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: pc=%h depth=%0d ovf=%b unf=%b, expected pc=00 depth=0 flags=0",
                 k, current_address, stack_depth, stack_overflow, stack_underflow);
      end
    end
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 3'd0, 0, 0, 0);
      n_tests++;
      if (current_address !== exp_pc[k]) begin
        n_fail++;
        $display("FAIL reset_inc[%0d]: pc=%h expected %h", k, current_address, exp_pc[k]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] exp_pc [3] = '{8'hFE, 8'hFF, 8'h00};
    logic [2:0]    ops    [3] = '{3'd1, 3'd0, 3'd0};
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, ops[k], 0, 8'hFE, 0);
      n_tests++;
      if (current_address !== exp_pc[k] || stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap[%0d]: pc=%h ovf=%b unf=%b expected pc=%h no flags",
                 k, current_address, stack_overflow, stack_underflow, exp_pc[k]);
      end
    end
  endtask

  task automatic test_branch;
    logic          cs     [3] = '{1'b0, 1'b1, 1'b1};
    logic [AW-1:0] offs   [3] = '{8'hF0, 8'hF0, 8'h05};
    logic [AW-1:0] exp_pc [3] = '{8'h21, 8'h11, 8'h16};
    cycle(0, 0, 3'd1, 0, 8'h20, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 3'd2, cs[k], 8'h77, offs[k]);
      n_tests++;
      if (obs_nxt !== exp_pc[k] || current_address !== exp_pc[k]) begin
        n_fail++;
        $display("FAIL branch[%0d]: next=%h pc=%h expected %h", k, obs_nxt, current_address, exp_pc[k]);
      end
    end
  endtask

  task automatic test_call_ret;
    logic [2:0]    ops    [4] = '{3'd3, 3'd3, 3'd4, 3'd4};
    logic [AW-1:0] tgts   [4] = '{8'h40, 8'h80, 8'h00, 8'h00};
    logic [AW-1:0] exp_pc [4] = '{8'h40, 8'h80, 8'h41, 8'h11};
    int            exp_d  [4] = '{1, 2, 1, 0};
    cycle(1, 0, 3'd0, 0, 0, 0);
    cycle(0, 0, 3'd1, 0, 8'h10, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, ops[k], 0, tgts[k], 0);
      n_tests++;
      if (current_address !== exp_pc[k] || int'(stack_depth) != exp_d[k] ||
          stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
        n_fail++;
        $display("FAIL call_ret[%0d]: pc=%h depth=%0d ovf=%b unf=%b expected pc=%h depth=%0d no flags",
                 k, current_address, stack_depth, stack_overflow, stack_underflow, exp_pc[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_overflow_underflow;
    logic [AW-1:0] tgts    [5] = '{8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
    int            call_d  [5] = '{1, 2, 3, 4, 4};
    logic [AW-1:0] ret_pc  [5] = '{8'h51, 8'h41, 8'h31, 8'h11, 8'h12};
    int            ret_d   [5] = '{3, 2, 1, 0, 0};
    cycle(1, 0, 3'd0, 0, 0, 0);
    cycle(0, 0, 3'd1, 0, 8'h10, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 3'd3, 0, tgts[k], 0);
      n_tests++;
      if (current_address !== tgts[k] || int'(stack_depth) != call_d[k] ||
          stack_overflow !== (k == 4) || stack_underflow !== 1'b0) begin
        n_fail++;
        $display("FAIL overflow_call[%0d]: pc=%h depth=%0d ovf=%b unf=%b expected pc=%h depth=%0d ovf=%b unf=0",
                 k, current_address, stack_depth, stack_overflow, stack_underflow, tgts[k], call_d[k], k == 4);
      end
    end
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 3'd4, 0, 0, 0);
      n_tests++;
      if (current_address !== ret_pc[k] || int'(stack_depth) != ret_d[k] ||
          stack_overflow !== 1'b1 || stack_underflow !== (k == 4)) begin
        n_fail++;
        $display("FAIL underflow_ret[%0d]: pc=%h depth=%0d ovf=%b unf=%b expected pc=%h depth=%0d ovf=1 unf=%b",
                 k, current_address, stack_depth, stack_overflow, stack_underflow, ret_pc[k], ret_d[k], k == 4);
      end
    end
    cycle(0, 0, 3'd0, 0, 0, 0);
    n_tests++;
    if (stack_overflow !== 1'b1 || stack_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL flags_sticky: ovf=%b unf=%b expected 1 1", stack_overflow, stack_underflow);
    end
    cycle(1, 0, 3'd3, 0, 8'h99, 0);
    n_tests++;
    if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0 || stack_depth !== '0 || current_address !== 8'h00) begin
      n_fail++;
      $display("FAIL flags_reset: pc=%h depth=%0d ovf=%b unf=%b expected 00 0 0 0",
               current_address, stack_depth, stack_overflow, stack_underflow);
    end
  endtask

  task automatic test_stall;
    cycle(1, 0, 3'd0, 0, 0, 0);
    cycle(0, 0, 3'd1, 0, 8'h33, 0);
    cycle(0, 0, 3'd3, 0, 8'h44, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 3'd3, 0, 8'h99, 0);
      n_tests++;
      if (obs_nxt !== 8'h44 || current_address !== 8'h44 || int'(stack_depth) != 1 ||
          stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: next=%h pc=%h depth=%0d ovf=%b unf=%b expected 44 44 1 0 0",
                 k, obs_nxt, current_address, stack_depth, stack_overflow, stack_underflow);
      end
    end
    cycle(0, 0, 3'd3, 0, 8'h99, 0);
    n_tests++;
    if (current_address !== 8'h99 || int'(stack_depth) != 2) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h depth=%0d expected 99 2", current_address, stack_depth);
    end
    cycle(0, 0, 3'd4, 0, 0, 0);
    n_tests++;
    if (current_address !== 8'h45 || int'(stack_depth) != 1) begin
      n_fail++;
      $display("FAIL stall_ret: pc=%h depth=%0d expected 45 1", current_address, stack_depth);
    end
  endtask

  task automatic test_random;
    bit r, s;
    cycle(1, 0, 3'd0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 3) == 0);
      cycle(r, s, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            AW'($urandom), AW'($urandom));
      if (!r) begin
        n_tests++;
        if (obs_nxt !== AW'(exp_nxt)) begin
          n_fail++;
          $display("FAIL rand_next[%0d]: next=%h expected %h", k, obs_nxt, AW'(exp_nxt));
        end
      end
      n_tests++;
      if (current_address !== AW'(m_pc) || int'(stack_depth) != m_stk.size() ||
          stack_overflow !== m_ovf || stack_underflow !== m_unf) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: pc=%h depth=%0d ovf=%b unf=%b expected pc=%h depth=%0d ovf=%b unf=%b",
                 k, current_address, stack_depth, stack_overflow, stack_underflow,
                 AW'(m_pc), m_stk.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    m_pc = 0; m_ovf = 0; m_unf = 0;
    @(posedge clock);
    #1;
    test_reset();
    test_wrap();
    test_branch();
    test_call_ret();
    test_overflow_underflow();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
